// File: rtl/bsg_and_rr_arb.sv
// Round-robin arbiter sharing one bitwise AND unit among num_req_p requesters;
// results go through a 2-entry FIFO. Define BSG_AND_RR_ARB_ZERO_FLAG_EN to add zero_o.
module bsg_and_rr_arb #(
   parameter int unsigned width_p = 16,
   parameter int unsigned num_req_p = 4,
   localparam int unsigned tag_width_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
   input  logic                           clk_i,
   input  logic                           reset_i,
   input  logic [num_req_p-1:0]           v_i,
   input  logic [num_req_p*width_p-1:0]   a_i,
   input  logic [num_req_p*width_p-1:0]   b_i,
   output logic [num_req_p-1:0]           yumi_o,
   output logic                           v_o,
   output logic [width_p-1:0]             data_o,
   output logic [tag_width_lp-1:0]        tag_o,
`ifdef BSG_AND_RR_ARB_ZERO_FLAG_EN
   output logic                           zero_o,
`endif
   input  logic                           yumi_i
);

   logic [width_p-1:0]      data_mem [2];
   logic [tag_width_lp-1:0] tag_mem  [2];
`ifdef BSG_AND_RR_ARB_ZERO_FLAG_EN
   logic                    zero_mem [2];
`endif

   logic [1:0]              count;
   logic                    rd_ptr;
   logic                    wr_ptr;
   logic [tag_width_lp-1:0] last;

   logic [num_req_p-1:0]    grant;
   logic [tag_width_lp-1:0] grant_idx;
   logic [tag_width_lp-1:0] scan;
   logic                    found;
   logic [width_p-1:0]      and_result;
   logic                    enq;
   logic                    deq;

   // Search starts one past the last winner and wraps, so priority rotates.
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      scan      = '0;
      found     = 1'b0;
      if (count < 2'd2) begin
         for (int unsigned i = 1; i <= num_req_p; i++) begin
            scan = tag_width_lp'((32'(last) + i) % num_req_p);
            if (!found && v_i[scan]) begin
               found     = 1'b1;
               grant_idx = scan;
            end
         end
      end
      if (found) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      and_result = '0;
      for (int unsigned k = 0; k < num_req_p; k++) begin
         if (grant[k]) begin
            and_result = a_i[k*width_p +: width_p] & b_i[k*width_p +: width_p];
         end
      end
   end

   assign yumi_o = grant;
   assign enq    = found;
   assign deq    = yumi_i & v_o;

   assign v_o    = (count != 2'd0);
   assign data_o = data_mem[rd_ptr];
   assign tag_o  = tag_mem[rd_ptr];
`ifdef BSG_AND_RR_ARB_ZERO_FLAG_EN
   assign zero_o = zero_mem[rd_ptr] & v_o;
`endif

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count       <= '0;
         rd_ptr      <= 1'b0;
         wr_ptr      <= 1'b0;
         last        <= tag_width_lp'(num_req_p - 1);
         data_mem[0] <= '0;
         data_mem[1] <= '0;
         tag_mem[0]  <= '0;
         tag_mem[1]  <= '0;
`ifdef BSG_AND_RR_ARB_ZERO_FLAG_EN
         zero_mem[0] <= 1'b0;
         zero_mem[1] <= 1'b0;
`endif
      end else begin
         if (enq) begin
            data_mem[wr_ptr] <= and_result;
            tag_mem[wr_ptr]  <= grant_idx;
`ifdef BSG_AND_RR_ARB_ZERO_FLAG_EN
            zero_mem[wr_ptr] <= (and_result == '0);
`endif
            wr_ptr           <= ~wr_ptr;
            last             <= grant_idx;
         end
         if (deq) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({enq, deq})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule
